hazard_scoreboard_ctrl: RTL and testbench
=========================================

// Module: hazard_scoreboard_ctrl
// PURPOSE
//  Parametrised pipeline hazard/stall controller for the in-order 5-stage SCPU.
//  Uses a per-register countdown scoreboard instead of fixed stage-compare logic,
//  so ALU/load latency and the forwarding mode are set by parameters.
//  Adds a branch-wait FSM, debug freeze/step and saturating stall counters.
//  Sits beside the decoder; drives the IF/ID/EXE stage enables and resets.
// PARAMETERS
//  NREG      32  architectural registers; AW = clog2(NREG) index width
//  ALU_LAT   0   stall cycles for an ALU result consumed back-to-back (0 = full forwarding)
//  LOAD_LAT  1   stall cycles for a load result consumed back-to-back
//  CNT_W     16  width of the performance counters
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     reset; one clock; reset is asynchronous and active-low
//  debug_en       in   1     freeze pipeline unless stepping
//  debug_step     in   1     step request; rising edge = one-cycle advance
//  id_valid       in   1     ID holds a real instruction
//  id_rs, id_rt   in   AW    ID source registers
//  id_rs_used     in   1     id_rs is read
//  id_rt_used     in   1     id_rt is read
//  id_rd          in   AW    ID destination register
//  id_we          in   1     ID writes id_rd
//  id_is_load     in   1     ID is a load
//  id_is_branch   in   1     ID is beq/bne/j/jal/jr/jalr
//  br_resolved    in   1     EXE resolves the outstanding branch this cycle
//  if_en          out  1     PC/IF enable
//  id_en          out  1     IF/ID register enable
//  id_rst         out  1     clear IF/ID (squash fetched slot)
//  exe_rst        out  1     clear ID/EX (insert bubble)
//  stall          out  1     data hazard this cycle
//  branch_stall   out  1     branch issue or branch wait this cycle
//  stall_cycles   out  CNT_W saturating count of stall cycles
//  branch_cycles  out  CNT_W saturating count of branch_stall cycles
// BEHAVIOUR
//  Reset (rst_n=0, async): cnt[*]=0; state=RUN; step_prev=0; counters=0.
//   While asserted: if_en=id_en=0, id_rst=exe_rst=1, stall=branch_stall=0.
//  Scoreboard: cnt[r] is CW bits, CW = clog2(max(ALU_LAT,LOAD_LAT)+1), min 1.
//   Every non-frozen cycle, each nonzero cnt decrements by 1. cnt[0] is always 0.
//  hazard = id_valid & ((id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0)).
//  issue = id_valid & ~hazard & state==RUN & ~freeze.
//   On issue with id_we and id_rd!=0:
//    cnt[id_rd] <= max(cnt[id_rd]-1 sat 0, L), where L = id_is_load ? LOAD_LAT : ALU_LAT.
//   This preserves WAW ordering.
//   A dependent instruction directly behind stalls exactly L cycles.
//  freeze = debug_en & ~(debug_step & ~step_prev); step_prev <= debug_step every cycle.
//   freeze holds cnt, FSM and counters.
//  FSM: RUN -> BR_WAIT on issue & id_is_branch.
//   BR_WAIT -> RUN on br_resolved (not frozen).
//   br_resolved in RUN is ignored.
//  Output priority, highest first (defaults: if_en=id_en=1, rsts=0):
//   1 freeze:          if_en=id_en=0; no resets; stall=branch_stall=0.
//   2 BR_WAIT, no br_resolved: if_en=0, id_rst=1, exe_rst=1, branch_stall=1.
//   3 BR_WAIT & br_resolved:   if_en=1, id_rst=1, branch_stall=1.
//     PC loads target or fall-through via datapath.
//   4 hazard (RUN):    if_en=0, id_en=0, exe_rst=1, stall=1.
//   5 issue & branch:  if_en=0, id_rst=1, branch_stall=1; branch itself enters EXE.
//  Counters: +1 when stall / branch_stall is asserted (not frozen); saturate at all-ones.
//  Reset mid-BR_WAIT or with pending cnt: everything clears; RUN on first edge after release.
// TESTING
//  1 ALU_LAT=0: add r3 then add r4,r3 -> stall never 1, if_en stays 1.
//  2 LOAD_LAT=1: lw r5 then add r6,r5 -> stall=1 and exe_rst=1 for exactly 1 cycle; stall_cycles=1.
//  3 ALU_LAT=3 (no-forward build): add r3; sub r7,r3 -> 3 stall cycles.
//    lw r3 then add r3 (WAW), then reader -> reader waits for the later write only.
//  4 Writes to r0, or reader with rs_used=rt_used=0 -> no stall.
//  5 beq issues, br_resolved after 2 cycles -> branch_stall high 3 cycles, then RUN.
//    branch_cycles=3; stray br_resolved in RUN -> no effect.
//  6 debug_en=1 -> all enables 0 and cnt frozen; one debug_step edge -> one advance.
//    rst_n low mid-BR_WAIT with cnt[5]=1 -> cnt/FSM/counters all 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard/stall controller for the in-order 5-stage SCPU: a per-register countdown
// scoreboard, a branch-wait FSM, debug freeze/step and saturating stall counters.
module hazard_scoreboard_ctrl #(
  parameter int NREG     = 32,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             debug_en,
  input  logic             debug_step,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  input  logic             br_resolved,
  output logic             if_en,
  output logic             id_en,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             stall,
  output logic             branch_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] branch_cycles
);

  localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  localparam logic [CW-1:0] ALU_L  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] BR_WAIT = 1'b1;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    if (v == '0) return '0;
    return v - 1'b1;
  endfunction

  function automatic logic [CW-1:0] lat_max(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (!en || v == '1) return v;
    return v + 1'b1;
  endfunction

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          step_prev;
  logic          freeze;
  logic          hazard;
  logic          issue;
  logic [CW-1:0] lat_sel;

  assign freeze  = debug_en & ~(debug_step & ~step_prev);
  assign hazard  = id_valid & ((id_rs_used & (cnt[id_rs] != '0)) |
                               (id_rt_used & (cnt[id_rt] != '0)));
  assign issue   = id_valid & ~hazard & (state == RUN) & ~freeze;
  assign lat_sel = id_is_load ? LOAD_L : ALU_L;

  // Taking the max with the decayed count keeps a later, shorter write from
  // releasing a reader before an earlier, longer write to the same register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = sat_dec(cnt[r]);
      if (r != 0 && issue && id_we && id_rd == AW'(r))
        cnt_nxt[r] = lat_max(cnt_nxt[r], lat_sel);
    end
    cnt_nxt[0] = '0;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && issue && id_is_branch)
      state_nxt = BR_WAIT;
    else if (state == BR_WAIT && br_resolved && !freeze)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!freeze) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      step_prev     <= 1'b0;
      stall_cycles  <= '0;
      branch_cycles <= '0;
    end else begin
      state     <= state_nxt;
      step_prev <= debug_step;
      if (!freeze) begin
        stall_cycles  <= sat_inc(stall_cycles, stall);
        branch_cycles <= sat_inc(branch_cycles, branch_stall);
      end
    end
  end

  // Resolve cycle keeps the squash on IF/ID but lets the PC load the branch outcome.
  always_comb begin
    if_en        = 1'b1;
    id_en        = 1'b1;
    id_rst       = 1'b0;
    exe_rst      = 1'b0;
    stall        = 1'b0;
    branch_stall = 1'b0;
    if (!rst_n) begin
      if_en   = 1'b0;
      id_en   = 1'b0;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
    end else if (freeze) begin
      if_en = 1'b0;
      id_en = 1'b0;
    end else if (state == BR_WAIT && !br_resolved) begin
      if_en        = 1'b0;
      id_rst       = 1'b1;
      exe_rst      = 1'b1;
      branch_stall = 1'b1;
    end else if (state == BR_WAIT) begin
      id_rst       = 1'b1;
      branch_stall = 1'b1;
    end else if (hazard) begin
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
      stall   = 1'b1;
    end else if (issue && id_is_branch) begin
      if_en        = 1'b0;
      id_rst       = 1'b1;
      branch_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scoreboard bench for hazard_scoreboard_ctrl: a register-ready-time model predicts
// every cycle's outputs, a monitor compares them on the falling edge.
module tb_hazard_scoreboard_ctrl;
  localparam int NREG     = 8;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int AW       = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debug_en = 1'b0, debug_step = 1'b0;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic id_we = 1'b0, id_is_load = 1'b0, id_is_branch = 1'b0, br_resolved = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic if_en, id_en, id_rst, exe_rst, stall, branch_stall;
  logic [CNT_W-1:0] stall_cycles, branch_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(.NREG(NREG), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .id_is_branch(id_is_branch), .br_resolved(br_resolved), .if_en(if_en), .id_en(id_en),
    .id_rst(id_rst), .exe_rst(exe_rst), .stall(stall), .branch_stall(branch_stall),
    .stall_cycles(stall_cycles), .branch_cycles(branch_cycles)
  );

  typedef struct packed {
    logic if_en, id_en, id_rst, exe_rst, stall, branch_stall;
    logic [CNT_W-1:0] sc, bc;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each register has a tick at which its value becomes available.
  int tick;
  int ready [NREG];
  bit m_br, m_sp;
  int m_sc, m_bc;

  task automatic model_reset();
    tick = 0;
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    m_br = 0; m_sp = 0; m_sc = 0; m_bc = 0;
  endtask

  task automatic model_step();
    exp_t e;
    bit frz, haz, iss;
    int lat;
    e = '0;
    if (!rst_n) begin
      e.id_rst = 1; e.exe_rst = 1;
      exp_q.push_back(e);
      model_reset();
      return;
    end
    frz = debug_en && !(debug_step && !m_sp);
    haz = id_valid && ((id_rs_used && ready[id_rs] > tick) || (id_rt_used && ready[id_rt] > tick));
    iss = id_valid && !haz && !m_br && !frz;
    e.if_en = 1; e.id_en = 1;
    if (frz) begin
      e.if_en = 0; e.id_en = 0;
    end else if (m_br && !br_resolved) begin
      e.if_en = 0; e.id_rst = 1; e.exe_rst = 1; e.branch_stall = 1;
    end else if (m_br) begin
      e.id_rst = 1; e.branch_stall = 1;
    end else if (haz) begin
      e.if_en = 0; e.id_en = 0; e.exe_rst = 1; e.stall = 1;
    end else if (iss && id_is_branch) begin
      e.if_en = 0; e.id_rst = 1; e.branch_stall = 1;
    end
    e.sc = CNT_W'(m_sc);
    e.bc = CNT_W'(m_bc);
    exp_q.push_back(e);
    m_sp = debug_step;
    if (!frz) begin
      if (e.stall && m_sc < CMAX) m_sc++;
      if (e.branch_stall && m_bc < CMAX) m_bc++;
      if (iss && id_we && id_rd != 0) begin
        lat = id_is_load ? LOAD_LAT : ALU_LAT;
        if (tick + 1 + lat > ready[id_rd]) ready[id_rd] = tick + 1 + lat;
      end
      if (m_br) begin
        if (br_resolved) m_br = 0;
      end else if (iss && id_is_branch) begin
        m_br = 1;
      end
      tick++;
    end
  endtask

  task automatic apply(input int rn, input int v, input int rs, input int rt, input int rsu,
                       input int rtu, input int rd, input int we, input int ld, input int br,
                       input int brr, input int de, input int ds);
    @(posedge clk); #1;
    rst_n = (rn != 0); id_valid = (v != 0); id_rs = AW'(rs); id_rt = AW'(rt);
    id_rs_used = (rsu != 0); id_rt_used = (rtu != 0); id_rd = AW'(rd); id_we = (we != 0);
    id_is_load = (ld != 0); id_is_branch = (br != 0); br_resolved = (brr != 0);
    debug_en = (de != 0); debug_step = (ds != 0);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {if_en, id_en, id_rst, exe_rst, stall, branch_stall, stall_cycles, branch_cycles};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got en=%b%b rst=%b%b st=%b bs=%b sc=%0d bc=%0d, expected en=%b%b rst=%b%b st=%b bs=%b sc=%0d bc=%0d",
                   $time, a.if_en, a.id_en, a.id_rst, a.exe_rst, a.stall, a.branch_stall, a.sc, a.bc,
                   e.if_en, e.id_en, e.id_rst, e.exe_rst, e.stall, e.branch_stall, e.sc, e.bc);
        end
      end
    end
  end

  initial begin : stim
    int dbg;
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load r5, then add r6,r5 held in ID until it issues
    apply(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < LOAD_LAT + 1; i++) apply(1, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    check_int("load_use_stall_cycles", int'(stall_cycles), LOAD_LAT);
    // writes to r0 and unused sources never stall
    apply(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 4, 4, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    idle(4);
    @(negedge clk);
    check_int("r0_unused_no_stall", int'(stall_cycles), LOAD_LAT);
    // WAW: load r3 then alu r3; reader waits for the longer outstanding write
    apply(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < LOAD_LAT; i++) apply(1, 1, 0, 3, 0, 1, 7, 1, 0, 0, 0, 0, 0);
    idle(2);
    // branch resolved after two cycles, then a stray resolve in RUN
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    idle(1);
    @(negedge clk);
    check_int("branch_cycles", int'(branch_cycles), 3);
    // debug freeze with one step edge in the middle of a load-use stall
    apply(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    apply(1, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    apply(1, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1);
    apply(1, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1);
    apply(1, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(4);
    // reset asserted mid-BR_WAIT with a pending load on r5
    apply(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_int("reset_clears_stall", int'(stall), 0);
    idle(2);
    // randomized traffic
    dbg = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) dbg = 1 - dbg;
      apply(($urandom_range(499) != 0) ? 1 : 0, ($urandom_range(99) < 80) ? 1 : 0,
            $urandom_range(NREG - 1), $urandom_range(NREG - 1),
            ($urandom_range(99) < 70) ? 1 : 0, ($urandom_range(99) < 50) ? 1 : 0,
            $urandom_range(NREG - 1), ($urandom_range(99) < 70) ? 1 : 0,
            ($urandom_range(99) < 30) ? 1 : 0, ($urandom_range(99) < 10) ? 1 : 0,
            ($urandom_range(99) < 30) ? 1 : 0, dbg, $urandom_range(1));
    end
    idle(3);
    repeat (4) @(negedge clk);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
